// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder: FSM state encoding,
// default wait-state latency and the address checks used at access time.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEFAULT_LATENCY = 2;
  localparam logic [31:0] WORD_ALIGN_MASK = 32'h0000_0003;

  // Full 30-bit word index is compared so high addresses never alias into the array
  function automatic logic access_error(input logic [31:0] addr, input logic [29:0] depth);
    return ((addr & WORD_ALIGN_MASK) != 32'd0) || (addr[31:2] >= depth);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the core's memory path and the responder.
interface mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_responder_mem_array.sv
// Word-addressed storage: one synchronous write port, combinational read, no reset.
module mem_array #(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one request at a time, waits LATENCY cycles,
// then performs the access and holds the response until the core takes it.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = DEFAULT_LATENCY
) (
  input  logic                           clk,
  input  logic                           reset,
  mem_responder_if.slave                 bus,
  input  logic                           ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
  input  logic [31:0]                    ld_data
);

  localparam int          IDX_W       = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT    = 4'(LATENCY - 1);

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        do_access;
  logic        access_err;
  logic [IDX_W-1:0] idx;

  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  assign idx        = addr_q[IDX_W+1:2];
  assign access_err = access_error(addr_q, DEPTH_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Preload has priority over a new request while idle
  always_comb begin
    next_state     = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    accept         = 1'b0;
    do_access      = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = ~ld_en;
        accept        = bus.req_valid & ~ld_en;
        if (accept) next_state = WAIT;
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          do_access  = 1'b1;
          next_state = RESP;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ld_addr;
    mem_wdata = ld_data;
    if (state == IDLE && ld_en) begin
      mem_we = 1'b1;
    end else if (do_access && wr_q && !access_err) begin
      mem_we    = 1'b1;
      mem_waddr = idx;
      mem_wdata = wdata_q;
    end
  end

  // Request capture, wait counter and registered response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        wr_q    <= bus.req_write;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        cnt     <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      if (do_access) begin
        err_q   <= access_err;
        rdata_q <= (access_err || wr_q) ? 32'd0 : mem_rdata;
      end else if (state == RESP && bus.resp_ready) begin
        err_q   <= 1'b0;
        rdata_q <= 32'd0;
      end
    end
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .raddr(idx),
    .rdata(mem_rdata)
  );

endmodule
